// File: rtl/gpio_input_capture.sv
// rtl/gpio_input_capture.sv - debounced GPIO input capture with edge-pending interrupt registers
module gpio_input_capture #(
  parameter int WIDTH           = 20,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             read,
  input  logic             write,
  input  logic [31:0]      address,
  input  logic [31:0]      write_data,
  output logic [31:0]      read_data,
  input  logic [WIDTH-1:0] gpio_in,
  output logic             irq
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] REG_INPUT    = 2'd0;
  localparam logic [1:0] REG_PENDING  = 2'd1;
  localparam logic [1:0] REG_ENABLE   = 2'd2;
  localparam logic [1:0] REG_EDGE_SEL = 2'd3;

  logic [WIDTH-1:0]         s1_q, s1_d;
  logic [WIDTH-1:0]         s2_q, s2_d;
  logic [WIDTH-1:0]         deb_q, deb_d;
  logic [WIDTH-1:0]         deb_prev_q, deb_prev_d;
  logic [WIDTH-1:0][CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]         pending_q, pending_d;
  logic [WIDTH-1:0]         enable_q, enable_d;
  logic [WIDTH-1:0]         edge_sel_q, edge_sel_d;

  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] pend_set;
  logic [WIDTH-1:0] pend_clr;
  logic [WIDTH-1:0] rd_sel;
  logic [1:0]       reg_sel;
  logic             unused_bus_bits;

  assign reg_sel         = address[3:2];
  assign unused_bus_bits = ^{address[31:4], address[1:0], write_data[31:WIDTH]};

  // Two-flop synchronizer and the one-cycle-delayed debounced level for edge detection
  always_comb begin
    s1_d       = gpio_in;
    s2_d       = s1_q;
    deb_prev_d = deb_q;
  end

  // Per-pin debounce: a new level is accepted only after it persists for DEBOUNCE_CYCLES cycles
  always_comb begin
    deb_d = deb_q;
    cnt_d = cnt_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (s2_q[i] == deb_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        deb_d[i] = s2_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  // Edge selection and pending update; a freshly detected edge beats a same-cycle clear
  always_comb begin
    rise      = deb_q & ~deb_prev_q;
    fall      = ~deb_q & deb_prev_q;
    pend_set  = (~edge_sel_q & rise) | (edge_sel_q & fall);
    pend_clr  = (write && reg_sel == REG_PENDING) ? write_data[WIDTH-1:0] : '0;
    pending_d = (pending_q & ~pend_clr) | pend_set;
  end

  // Plain read/write control registers
  always_comb begin
    enable_d   = enable_q;
    edge_sel_d = edge_sel_q;
    if (write && reg_sel == REG_ENABLE) begin
      enable_d = write_data[WIDTH-1:0];
    end
    if (write && reg_sel == REG_EDGE_SEL) begin
      edge_sel_d = write_data[WIDTH-1:0];
    end
  end

  // Combinational read mux, zero when no read is in progress
  always_comb begin
    rd_sel = '0;
    case (reg_sel)
      REG_INPUT:    rd_sel = deb_q;
      REG_PENDING:  rd_sel = pending_q;
      REG_ENABLE:   rd_sel = enable_q;
      REG_EDGE_SEL: rd_sel = edge_sel_q;
      default:      rd_sel = '0;
    endcase
    read_data = read ? {{(32 - WIDTH){1'b0}}, rd_sel} : 32'h0000_0000;
  end

  assign irq = |(pending_q & enable_q);

  // State registers with synchronous active-high reset
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q       <= '0;
      s2_q       <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      cnt_q      <= '0;
      pending_q  <= '0;
      enable_q   <= '0;
      edge_sel_q <= '0;
    end else begin
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      deb_q      <= deb_d;
      deb_prev_q <= deb_prev_d;
      cnt_q      <= cnt_d;
      pending_q  <= pending_d;
      enable_q   <= enable_d;
      edge_sel_q <= edge_sel_d;
    end
  end

endmodule

// File: tb/tb_gpio_input_capture.sv
// tb/tb_gpio_input_capture.sv - scoreboard bench for gpio_input_capture
module tb_gpio_input_capture;

  localparam int WIDTH = 20;
  localparam int DEB   = 4;

  localparam logic [31:0] A_INPUT    = 32'h0;
  localparam logic [31:0] A_PENDING  = 32'h4;
  localparam logic [31:0] A_ENABLE   = 32'h8;
  localparam logic [31:0] A_EDGE_SEL = 32'hC;

  logic             clk = 1'b0;
  logic             reset;
  logic             read;
  logic             write;
  logic [31:0]      address;
  logic [31:0]      write_data;
  logic [31:0]      read_data;
  logic [WIDTH-1:0] gpio_in;
  logic             irq;

  logic             sample;

  typedef struct {
    string       name;
    logic [31:0] data;
    logic        irq;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;

  gpio_input_capture #(.WIDTH(WIDTH), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk        (clk),
    .reset      (reset),
    .read       (read),
    .write      (write),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .gpio_in    (gpio_in),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  // Monitor: pops one expectation per sampled cycle, away from the rising edge
  always @(negedge clk) begin
    if (sample) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL scoreboard_empty: sample with no expectation queued");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checks++;
        if (read_data === e.data) passes++;
        else $display("FAIL %s.read_data: got %h expected %h", e.name, read_data, e.data);
        checks++;
        if (irq === e.irq) passes++;
        else $display("FAIL %s.irq: got %b expected %b", e.name, irq, e.irq);
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [31:0] exp_data,
                         input logic exp_irq, input string name);
    exp_t e;
    e.name = name; e.data = exp_data; e.irq = exp_irq;
    exp_q.push_back(e);
    read = 1'b1; address = addr; sample = 1'b1;
    tick();
    read = 1'b0; sample = 1'b0;
  endtask

  task automatic do_peek(input logic [31:0] addr, input logic exp_irq, input string name);
    exp_t e;
    e.name = name; e.data = 32'h0; e.irq = exp_irq;
    exp_q.push_back(e);
    read = 1'b0; address = addr; sample = 1'b1;
    tick();
    sample = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data);
    write = 1'b1; address = addr; write_data = data;
    tick();
    write = 1'b0; write_data = 32'h0;
  endtask

  initial begin
    reset = 1'b1; read = 1'b0; write = 1'b0; address = 32'h0;
    write_data = 32'h0; gpio_in = '0; sample = 1'b0;
    tick(3);
    reset = 1'b0;

    // Reset state
    do_read(A_INPUT,    32'h0, 1'b0, "rst_input");
    do_read(A_PENDING,  32'h0, 1'b0, "rst_pending");
    do_read(A_ENABLE,   32'h0, 1'b0, "rst_enable");
    do_read(A_EDGE_SEL, 32'h0, 1'b0, "rst_edge_sel");
    do_peek(A_PENDING,  1'b0, "rst_peek");

    // Pin3 rise: s1 at edge k, INPUT at k+5, PENDING at k+6
    gpio_in[3] = 1'b1;
    tick();
    for (int j = 0; j < 5; j++) do_read(A_INPUT, 32'h0, 1'b0, $sformatf("p3_input_j%0d", j));
    do_read(A_INPUT,   32'h8, 1'b0, "p3_input_j5");
    do_read(A_PENDING, 32'h8, 1'b0, "p3_pending_j6");

    // Pin0 rise observed through PENDING cycle by cycle
    gpio_in[0] = 1'b1;
    tick();
    for (int j = 0; j < 6; j++) do_read(A_PENDING, 32'h8, 1'b0, $sformatf("p0_pending_j%0d", j));
    do_read(A_PENDING, 32'h9, 1'b0, "p0_pending_j6");
    do_write(A_PENDING, 32'h9);
    do_read(A_PENDING, 32'h0, 1'b0, "w1c_all");

    // Glitch rejection on pin3 with enable set
    do_write(A_ENABLE, 32'h8);
    gpio_in[3] = 1'b0;
    tick(10);
    do_read(A_PENDING, 32'h0, 1'b0, "p3_fall_no_pend");
    gpio_in[3] = 1'b1;
    tick(3);
    gpio_in[3] = 1'b0;
    for (int j = 0; j < 7; j++) do_read(A_INPUT, 32'h1, 1'b0, $sformatf("glitch3_input_j%0d", j));
    do_read(A_PENDING, 32'h0, 1'b0, "glitch3_pending");
    // Four-cycle pulse is just long enough to be accepted
    gpio_in[3] = 1'b1;
    tick(4);
    gpio_in[3] = 1'b0;
    tick(10);
    do_read(A_PENDING, 32'h8, 1'b1, "pulse4_pending");
    do_write(A_PENDING, 32'h8);
    do_read(A_PENDING, 32'h0, 1'b0, "pulse4_cleared");

    // Falling-edge capture on pin0
    do_write(A_ENABLE,   32'h1);
    do_write(A_EDGE_SEL, 32'h1);
    do_read(A_EDGE_SEL, 32'h1, 1'b0, "edge_sel_rb");
    gpio_in[0] = 1'b0;
    tick(8);
    do_read(A_PENDING, 32'h1, 1'b1, "p0_fall_pending");
    do_write(A_PENDING, 32'h1);
    do_read(A_PENDING, 32'h0, 1'b0, "p0_fall_cleared");

    // W1C collides with the set of bit5 at edge k+6
    gpio_in[5] = 1'b1;
    tick();
    tick(5);
    do_write(A_PENDING, 32'h20);
    do_read(A_PENDING, 32'h20, 1'b0, "collide_set_wins");
    do_write(A_PENDING, 32'h20);
    do_read(A_PENDING, 32'h0, 1'b0, "collide_then_clear");

    // Read strobe gating, width masking, ignored INPUT writes
    do_peek(A_INPUT,    1'b0, "peek_input");
    do_peek(A_PENDING,  1'b0, "peek_pending");
    do_peek(A_ENABLE,   1'b0, "peek_enable");
    do_peek(A_EDGE_SEL, 1'b0, "peek_edge_sel");
    do_write(A_ENABLE, 32'hFFFF_FFFF);
    do_read(A_ENABLE, 32'h000F_FFFF, 1'b0, "enable_masked");
    do_read(32'h18,   32'h000F_FFFF, 1'b0, "enable_alias");
    do_write(A_INPUT, 32'h000F_FFFF);
    do_read(A_INPUT,  32'h20, 1'b0, "input_ro");

    // Reset in the middle of a pin7 debounce
    gpio_in[5] = 1'b0;
    tick(10);
    do_read(A_PENDING, 32'h0, 1'b0, "pre_p7_pending");
    gpio_in[7] = 1'b1;
    tick();
    tick(3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    do_read(A_PENDING,  32'h0, 1'b0, "p7_rst_pending");
    do_read(A_ENABLE,   32'h0, 1'b0, "p7_rst_enable");
    do_read(A_EDGE_SEL, 32'h0, 1'b0, "p7_rst_edge_sel");
    do_read(A_INPUT,    32'h0, 1'b0, "p7_input_r3");
    do_read(A_INPUT,    32'h0, 1'b0, "p7_input_r4");
    do_read(A_INPUT,    32'h0, 1'b0, "p7_input_r5");
    do_read(A_INPUT,    32'h80, 1'b0, "p7_input_r6");
    do_read(A_PENDING,  32'h80, 1'b0, "p7_pending_r7");

    tick(2);
    checks++;
    if (exp_q.size() == 0) passes++;
    else $display("FAIL scoreboard_drain: %0d left expected 0", exp_q.size());

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
